// File: rtl/l2_pkg.sv
// Shared types for the L2 miss controller: geometry, MESI, bus/snoop codes, FSM states.
package l2_pkg;

   localparam int TAG_W    = 12;
   localparam int INDEX_W  = 14;
   localparam int OFFSET_W = 6;
   localparam int WAYS     = 8;
   localparam int WAY_W    = 3;
   localparam int ADDR_W   = TAG_W + INDEX_W + OFFSET_W;

   typedef enum logic [1:0] {
      MESI_I = 2'd0,
      MESI_S = 2'd1,
      MESI_E = 2'd2,
      MESI_M = 2'd3
   } mesi_e;

   typedef enum logic [1:0] {
      BUS_RD   = 2'd0,
      BUS_RWIM = 2'd1,
      BUS_WB   = 2'd2,
      BUS_INV  = 2'd3
   } bus_cmd_e;

   typedef enum logic [1:0] {
      SNP_NOHIT = 2'd0,
      SNP_HIT   = 2'd1,
      SNP_HITM  = 2'd2,
      SNP_RSVD  = 2'd3
   } snoop_e;

   typedef enum logic [1:0] {
      OP_READ  = 2'd0,
      OP_WRITE = 2'd1,
      OP_RSV2  = 2'd2,
      OP_RSV3  = 2'd3
   } req_op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOOKUP,
      ST_DECIDE,
      ST_WB,
      ST_FILL,
      ST_UPGR,
      ST_UPDATE,
      ST_RESP
   } state_e;

   function automatic logic [WAY_W-1:0] lowest_way(input logic [WAYS-1:0] v);
      lowest_way = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (v[w]) lowest_way = WAY_W'(w);
      end
   endfunction

endpackage

// File: rtl/l2_victim_select.sv
// Victim way choice for one 8-way set: lowest invalid way, else tree-PLRU walk.
module l2_victim_select
   import l2_pkg::*;
(
   input  logic [2*WAYS-1:0] mesi,
   input  logic [WAYS-2:0]   plru,
   output logic [WAY_W-1:0]  victim,
   output logic              empty
);

   logic [WAYS-1:0]  inv;
   logic [WAY_W-1:0] plru_way;
   logic             b0;
   logic             b1;
   logic             b2;

   always_comb begin
      for (int w = 0; w < WAYS; w++) begin
         inv[w] = (mesi[2*w +: 2] == MESI_I);
      end
   end

   // node n has children 2n+1 / 2n+2; a 0 bit steers to the lower half
   always_comb begin
      b0       = plru[0];
      b1       = plru[3'd1 + {2'b00, b0}];
      b2       = plru[3'd3 + {1'b0, b0, b1}];
      plru_way = {b0, b1, b2};
   end

   assign empty  = |inv;
   assign victim = empty ? lowest_way(inv) : plru_way;

endmodule

// File: rtl/l2_miss_controller.sv
// L2 access sequencer: lookup, hit/miss, victim writeback, fill, tag/MESI/PLRU update.
// Define L2_STATS_EN to add saturating hit/miss/writeback counters.
module l2_miss_controller
   import l2_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [1:0]              req_op,
   input  logic [ADDR_W-1:0]       req_addr,
   output logic                    tag_rd_en,
   output logic [INDEX_W-1:0]      tag_rd_index,
   input  logic [WAYS-1:0]         tag_rd_hit_vec,
   input  logic [2*WAYS-1:0]       tag_rd_mesi,
   input  logic [WAYS-2:0]         tag_rd_plru,
   input  logic [TAG_W*WAYS-1:0]   tag_rd_tag,
   output logic                    tag_wr_en,
   output logic [WAY_W-1:0]        tag_wr_way,
   output logic [TAG_W-1:0]        tag_wr_tag,
   output logic [1:0]              tag_wr_mesi,
   output logic                    lru_upd_en,
   output logic [WAY_W-1:0]        lru_upd_way,
   output logic                    bus_valid,
   input  logic                    bus_ready,
   output logic [1:0]              bus_cmd,
   output logic [ADDR_W-1:0]       bus_addr,
   input  logic                    bus_done,
   input  logic [1:0]              bus_snoop,
   output logic                    resp_valid,
   output logic                    resp_hit,
   output logic [WAY_W-1:0]        resp_way
`ifdef L2_STATS_EN
   ,
   output logic [31:0]             stat_hits,
   output logic [31:0]             stat_misses,
   output logic [31:0]             stat_wbs
`endif
);

   state_e             state_q, state_d;
   logic               wr_q, wr_d;
   logic [TAG_W-1:0]   tag_q, tag_d;
   logic [INDEX_W-1:0] idx_q, idx_d;
   logic [WAY_W-1:0]   way_q, way_d;
   logic               hit_q, hit_d;
   logic [1:0]         mesi_q, mesi_d;
   logic               upd_tag_q, upd_tag_d;
   logic [TAG_W-1:0]   vtag_q, vtag_d;
   logic               bus_vld_q, bus_vld_d;
   logic               bus_wait_q, bus_wait_d;

   logic [WAY_W-1:0]   hit_way;
   logic [WAY_W-1:0]   vic_way;
   logic               vic_empty;
   logic [1:0]         hit_mesi;
   logic [1:0]         vic_mesi;
   logic [TAG_W-1:0]   vic_tag;
   logic               done_ok;

   l2_victim_select u_vsel (
      .mesi   (tag_rd_mesi),
      .plru   (tag_rd_plru),
      .victim (vic_way),
      .empty  (vic_empty)
   );

   assign hit_way = lowest_way(tag_rd_hit_vec);

   always_comb begin
      hit_mesi = '0;
      vic_mesi = '0;
      vic_tag  = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (hit_way == WAY_W'(w)) hit_mesi = tag_rd_mesi[2*w +: 2];
         if (vic_way == WAY_W'(w)) begin
            vic_mesi = tag_rd_mesi[2*w +: 2];
            vic_tag  = tag_rd_tag[TAG_W*w +: TAG_W];
         end
      end
   end

   // a done pulse only counts once the command has been handed over
   assign done_ok = bus_done & (bus_wait_q | (bus_vld_q & bus_ready));

   always_comb begin
      state_d    = state_q;
      wr_d       = wr_q;
      tag_d      = tag_q;
      idx_d      = idx_q;
      way_d      = way_q;
      hit_d      = hit_q;
      mesi_d     = mesi_q;
      upd_tag_d  = upd_tag_q;
      vtag_d     = vtag_q;
      bus_vld_d  = bus_vld_q;
      bus_wait_d = bus_wait_q;
      if (bus_vld_q && bus_ready) begin
         bus_vld_d  = 1'b0;
         bus_wait_d = 1'b1;
      end
      unique case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               state_d = ST_LOOKUP;
               wr_d    = (req_op == OP_WRITE);
               tag_d   = req_addr[ADDR_W-1 -: TAG_W];
               idx_d   = req_addr[OFFSET_W +: INDEX_W];
            end
         end
         ST_LOOKUP: state_d = ST_DECIDE;
         ST_DECIDE: begin
            if (|tag_rd_hit_vec) begin
               hit_d     = 1'b1;
               way_d     = hit_way;
               mesi_d    = MESI_M;
               upd_tag_d = wr_q;
               if (wr_q && hit_mesi == MESI_S) begin
                  state_d   = ST_UPGR;
                  bus_vld_d = 1'b1;
               end else begin
                  state_d = ST_UPDATE;
               end
            end else begin
               hit_d     = 1'b0;
               way_d     = vic_way;
               upd_tag_d = 1'b1;
               vtag_d    = vic_tag;
               bus_vld_d = 1'b1;
               state_d   = (!vic_empty && vic_mesi == MESI_M) ? ST_WB : ST_FILL;
            end
         end
         ST_WB: begin
            if (done_ok) begin
               state_d    = ST_FILL;
               bus_wait_d = 1'b0;
               bus_vld_d  = 1'b1;
            end
         end
         ST_FILL: begin
            if (done_ok) begin
               state_d    = ST_UPDATE;
               bus_wait_d = 1'b0;
               if (wr_q) mesi_d = MESI_M;
               else if (bus_snoop == SNP_NOHIT) mesi_d = MESI_E;
               else mesi_d = MESI_S;
            end
         end
         ST_UPGR: begin
            if (done_ok) begin
               state_d    = ST_UPDATE;
               bus_wait_d = 1'b0;
            end
         end
         ST_UPDATE: state_d = ST_RESP;
         ST_RESP:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         wr_q       <= 1'b0;
         tag_q      <= '0;
         idx_q      <= '0;
         way_q      <= '0;
         hit_q      <= 1'b0;
         mesi_q     <= '0;
         upd_tag_q  <= 1'b0;
         vtag_q     <= '0;
         bus_vld_q  <= 1'b0;
         bus_wait_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_q       <= wr_d;
         tag_q      <= tag_d;
         idx_q      <= idx_d;
         way_q      <= way_d;
         hit_q      <= hit_d;
         mesi_q     <= mesi_d;
         upd_tag_q  <= upd_tag_d;
         vtag_q     <= vtag_d;
         bus_vld_q  <= bus_vld_d;
         bus_wait_q <= bus_wait_d;
      end
   end

   assign req_ready    = (state_q == ST_IDLE);
   assign tag_rd_en    = (state_q == ST_LOOKUP);
   assign tag_rd_index = idx_q;
   assign tag_wr_en    = (state_q == ST_UPDATE) & upd_tag_q;
   assign tag_wr_way   = way_q;
   assign tag_wr_tag   = tag_q;
   assign tag_wr_mesi  = mesi_q;
   assign lru_upd_en   = (state_q == ST_UPDATE);
   assign lru_upd_way  = way_q;
   assign bus_valid    = bus_vld_q;
   assign resp_valid   = (state_q == ST_RESP);
   assign resp_hit     = resp_valid & hit_q;
   assign resp_way     = resp_valid ? way_q : '0;

   always_comb begin
      bus_cmd  = BUS_RD;
      bus_addr = {tag_q, idx_q, {OFFSET_W{1'b0}}};
      unique case (1'b1)
         state_q == ST_WB: begin
            bus_cmd  = BUS_WB;
            bus_addr = {vtag_q, idx_q, {OFFSET_W{1'b0}}};
         end
         state_q == ST_UPGR: bus_cmd = BUS_INV;
         state_q == ST_FILL: bus_cmd = wr_q ? BUS_RWIM : BUS_RD;
         default: ;
      endcase
   end

`ifdef L2_STATS_EN
   logic [31:0] hits_q, hits_d;
   logic [31:0] misses_q, misses_d;
   logic [31:0] wbs_q, wbs_d;

   always_comb begin
      hits_d   = hits_q;
      misses_d = misses_q;
      wbs_d    = wbs_q;
      if (state_q == ST_UPDATE) begin
         if (hit_q && hits_q != '1) hits_d = hits_q + 32'd1;
         if (!hit_q && misses_q != '1) misses_d = misses_q + 32'd1;
      end
      if (state_q == ST_DECIDE && state_d == ST_WB && wbs_q != '1) begin
         wbs_d = wbs_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hits_q   <= '0;
         misses_q <= '0;
         wbs_q    <= '0;
      end else begin
         hits_q   <= hits_d;
         misses_q <= misses_d;
         wbs_q    <= wbs_d;
      end
   end

   assign stat_hits   = hits_q;
   assign stat_misses = misses_q;
   assign stat_wbs    = wbs_q;
`endif

endmodule

// File: tb/tb_l2_miss_controller.sv
// Scoreboard bench for l2_miss_controller: bench acts as tag array, bus and front end.
module tb_l2_miss_controller;
   import l2_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic                  req_valid, req_ready;
   logic [1:0]            req_op;
   logic [ADDR_W-1:0]     req_addr;
   logic                  tag_rd_en;
   logic [INDEX_W-1:0]    tag_rd_index;
   logic [WAYS-1:0]       tag_rd_hit_vec;
   logic [2*WAYS-1:0]     tag_rd_mesi;
   logic [WAYS-2:0]       tag_rd_plru;
   logic [TAG_W*WAYS-1:0] tag_rd_tag;
   logic                  tag_wr_en;
   logic [WAY_W-1:0]      tag_wr_way;
   logic [TAG_W-1:0]      tag_wr_tag;
   logic [1:0]            tag_wr_mesi;
   logic                  lru_upd_en;
   logic [WAY_W-1:0]      lru_upd_way;
   logic                  bus_valid, bus_ready;
   logic [1:0]            bus_cmd;
   logic [ADDR_W-1:0]     bus_addr;
   logic                  bus_done;
   logic [1:0]            bus_snoop;
   logic                  resp_valid, resp_hit;
   logic [WAY_W-1:0]      resp_way;
`ifdef L2_STATS_EN
   logic [31:0]           stat_hits, stat_misses, stat_wbs;
`endif

   l2_miss_controller dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_addr(req_addr),
      .tag_rd_en(tag_rd_en), .tag_rd_index(tag_rd_index),
      .tag_rd_hit_vec(tag_rd_hit_vec), .tag_rd_mesi(tag_rd_mesi),
      .tag_rd_plru(tag_rd_plru), .tag_rd_tag(tag_rd_tag),
      .tag_wr_en(tag_wr_en), .tag_wr_way(tag_wr_way),
      .tag_wr_tag(tag_wr_tag), .tag_wr_mesi(tag_wr_mesi),
      .lru_upd_en(lru_upd_en), .lru_upd_way(lru_upd_way),
      .bus_valid(bus_valid), .bus_ready(bus_ready),
      .bus_cmd(bus_cmd), .bus_addr(bus_addr),
      .bus_done(bus_done), .bus_snoop(bus_snoop),
      .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_way(resp_way)
`ifdef L2_STATS_EN
      , .stat_hits(stat_hits), .stat_misses(stat_misses), .stat_wbs(stat_wbs)
`endif
   );

   typedef struct packed {
      logic [1:0]        cmd;
      logic [ADDR_W-1:0] addr;
   } bus_t;
   typedef struct packed {
      logic [WAY_W-1:0] way;
      logic [TAG_W-1:0] tag;
      logic [1:0]       mesi;
   } wr_t;
   typedef struct {
      logic             hit;
      logic [WAY_W-1:0] way;
      int               acc;
      bit               nobus;
   } resp_t;

   bus_t             exp_bus[$];
   wr_t              exp_wr[$];
   logic [WAY_W-1:0] exp_lru[$];
   resp_t            exp_resp[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [TAG_W-1:0] m_tag[16][WAYS];
   logic [1:0]       m_mesi[16][WAYS];
   logic [WAYS-2:0]  m_plru[16];

   logic [TAG_W-1:0] cur_tag = '0;
   logic [1:0]       cur_snoop = 2'd0;
   int               force_rdy = -1;
   int               force_done = -1;
   bit               bus_busy = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic bad(input string nm);
      checks++;
      errors++;
      $display("FAIL %s: event seen, none expected", nm);
   endtask

   function automatic logic [ADDR_W-1:0] line(input logic [TAG_W-1:0] t, input logic [3:0] s);
      return {t, 10'd0, s, 6'd0};
   endfunction

   initial forever @(posedge clk) cyc++;

   // tag array: answers a lookup strobe in the following cycle
   initial begin
      tag_rd_hit_vec = '0;
      tag_rd_mesi    = '0;
      tag_rd_plru    = '0;
      tag_rd_tag     = '0;
      forever begin
         @(negedge clk);
         if (tag_rd_en) begin
            for (int w = 0; w < WAYS; w++) begin
               tag_rd_hit_vec[w] = (m_mesi[tag_rd_index[3:0]][w] != 2'd0) &&
                                   (m_tag[tag_rd_index[3:0]][w] == cur_tag);
               tag_rd_mesi[2*w +: 2]         = m_mesi[tag_rd_index[3:0]][w];
               tag_rd_tag[TAG_W*w +: TAG_W] = m_tag[tag_rd_index[3:0]][w];
            end
            tag_rd_plru = m_plru[tag_rd_index[3:0]];
         end
      end
   end

   // write/lru/response monitor; also applies array updates
   initial forever begin
      @(negedge clk);
      if (tag_wr_en) begin
         if (exp_wr.size() == 0) bad("tag_wr_unexpected");
         else begin
            wr_t e;
            e = exp_wr.pop_front();
            chk("tag_wr", {tag_wr_way, tag_wr_tag, tag_wr_mesi}, e);
         end
         m_tag[tag_rd_index[3:0]][tag_wr_way]  = tag_wr_tag;
         m_mesi[tag_rd_index[3:0]][tag_wr_way] = tag_wr_mesi;
      end
      if (lru_upd_en) begin
         logic [WAYS-2:0] p;
         logic [2:0] w;
         if (exp_lru.size() == 0) bad("lru_unexpected");
         else chk("lru_way", lru_upd_way, exp_lru.pop_front());
         w = lru_upd_way;
         p = m_plru[tag_rd_index[3:0]];
         p[0] = ~w[2];
         p[3'd1 + {2'b00, w[2]}] = ~w[1];
         p[3'd3 + {1'b0, w[2], w[1]}] = ~w[0];
         m_plru[tag_rd_index[3:0]] = p;
      end
      if (resp_valid) begin
         if (exp_resp.size() == 0) bad("resp_unexpected");
         else begin
            resp_t r;
            r = exp_resp.pop_front();
            chk("resp_hit", resp_hit, r.hit);
            chk("resp_way", resp_way, r.way);
            if (r.nobus) chk("resp_latency", cyc - r.acc + 1, 4);
         end
      end
   end

   // system bus: random ready/done delays, command order checked
   initial begin
      bus_ready = 1'b0;
      bus_done  = 1'b0;
      bus_snoop = 2'd0;
      forever begin
         @(negedge clk);
         bus_ready = 1'b0;
         bus_done  = 1'b0;
         if (bus_valid) begin
            logic [1:0] c;
            logic [ADDR_W-1:0] a;
            int rd, dd;
            bus_busy = 1'b1;
            c = bus_cmd;
            a = bus_addr;
            if (exp_bus.size() == 0) bad("bus_unexpected");
            else begin
               bus_t e;
               e = exp_bus.pop_front();
               chk("bus_cmd", c, e.cmd);
               chk("bus_addr", a, e.addr);
            end
            rd = (force_rdy >= 0) ? force_rdy : int'($urandom_range(0, 2));
            for (int i = 0; i < rd; i++) begin
               @(negedge clk);
               chk("bus_hold", {bus_valid, bus_cmd, bus_addr}, {1'b1, c, a});
            end
            bus_ready = 1'b1;
            dd = (force_done >= 0) ? force_done : int'($urandom_range(0, 3));
            if (dd == 0) begin
               bus_done  = 1'b1;
               bus_snoop = cur_snoop;
            end
            @(negedge clk);
            bus_ready = 1'b0;
            bus_done  = 1'b0;
            if (dd != 0) begin
               chk("bus_drop", bus_valid, 1'b0);
               repeat (dd - 1) @(negedge clk);
               bus_done  = 1'b1;
               bus_snoop = cur_snoop;
               @(negedge clk);
               bus_done = 1'b0;
            end
            bus_busy = 1'b0;
         end
      end
   end

   // reference: outcome of one request from the current array contents
   task automatic predict(input bit wr, input logic [TAG_W-1:0] t, input logic [3:0] s,
                          input logic [1:0] snp, input int acc);
      int hw;
      resp_t r;
      hw = -1;
      for (int w = WAYS - 1; w >= 0; w--)
         if (m_mesi[s][w] != 2'd0 && m_tag[s][w] == t) hw = w;
      if (hw >= 0) begin
         r.nobus = 1'b1;
         if (wr) begin
            if (m_mesi[s][hw] == 2'd1) begin
               exp_bus.push_back({2'd3, line(t, s)});
               r.nobus = 1'b0;
            end
            exp_wr.push_back({3'(hw), t, 2'd3});
         end
         exp_lru.push_back(3'(hw));
         r.hit = 1'b1;
         r.way = 3'(hw);
      end else begin
         int v;
         logic [2:0] node;
         logic b;
         v = -1;
         for (int w = WAYS - 1; w >= 0; w--)
            if (m_mesi[s][w] == 2'd0) v = w;
         if (v < 0) begin
            v = 0;
            node = 3'd0;
            for (int l = 0; l < 3; l++) begin
               b = m_plru[s][node];
               v = v * 2 + int'(b);
               node = {node[1:0], 1'b0} + 3'd1 + {2'b00, b};
            end
         end
         if (m_mesi[s][v] == 2'd3) exp_bus.push_back({2'd2, line(m_tag[s][v], s)});
         exp_bus.push_back({wr ? 2'd1 : 2'd0, line(t, s)});
         exp_wr.push_back({3'(v), t, wr ? 2'd3 : (snp == 2'd0 ? 2'd2 : 2'd1)});
         exp_lru.push_back(3'(v));
         r.hit = 1'b0;
         r.way = 3'(v);
         r.nobus = 1'b0;
      end
      r.acc = acc;
      exp_resp.push_back(r);
   endtask

   task automatic issue(input logic [1:0] op, input logic [TAG_W-1:0] t,
                        input logic [3:0] s, input logic [1:0] snp);
      int to;
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = op;
      req_addr  = {t, 10'd0, s, 6'($urandom)};
      to = 0;
      while (!req_ready && to < 300) begin
         @(negedge clk);
         to++;
      end
      if (!req_ready) begin
         bad("req_ready_timeout");
         req_valid = 1'b0;
         return;
      end
      cur_tag   = t;
      cur_snoop = snp;
      predict(op == 2'd1, t, s, snp, cyc + 1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_op    = 2'($urandom);
      req_addr  = ADDR_W'($urandom);
   endtask

   task automatic wait_idle();
      int to;
      to = 0;
      while ((exp_resp.size() != 0 || bus_busy || !req_ready) && to < 2000) begin
         @(negedge clk);
         to++;
      end
      if (to >= 2000) bad("idle_timeout");
   endtask

   task automatic fill_set(input logic [3:0] s, input logic [1:0] m, input logic [WAYS-2:0] p);
      for (int w = 0; w < WAYS; w++) begin
         m_tag[s][w]  = TAG_W'(12'h100 + w);
         m_mesi[s][w] = m;
      end
      m_plru[s] = p;
   endtask

   initial begin
      int to;
      for (int s = 0; s < 16; s++) fill_set(4'(s), 2'd0, '0);
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_op    = 2'd0;
      req_addr  = '0;
      @(negedge clk);
      chk("rst_ready", req_ready, 1'b1);
      chk("rst_strobes", {tag_rd_en, tag_wr_en, lru_upd_en, bus_valid, resp_valid, resp_hit}, 6'd0);
      chk("rst_addr_way", {bus_addr, tag_rd_index, tag_wr_way, lru_upd_way, resp_way}, '0);
      @(negedge clk);
      rst_n = 1'b1;

      issue(2'd0, 12'h005, 4'd0, 2'd0);
      wait_idle();
      issue(2'd0, 12'h005, 4'd0, 2'd1);
      wait_idle();

      fill_set(4'd1, 2'd2, '0);
      m_mesi[1][7] = 2'd0;
      issue(2'd0, 12'h050, 4'd1, 2'd1);
      wait_idle();
      fill_set(4'd2, 2'd2, 7'b0000000);
      issue(2'd2, 12'h051, 4'd2, 2'd0);
      wait_idle();
      fill_set(4'd3, 2'd2, 7'b1111111);
      issue(2'd0, 12'h052, 4'd3, 2'd2);
      wait_idle();

      fill_set(4'd4, 2'd2, 7'b0000000);
      m_mesi[4][0] = 2'd3;
      force_rdy = 3;
      issue(2'd0, 12'h053, 4'd4, 2'd0);
      wait_idle();
      force_rdy = -1;

      fill_set(4'd5, 2'd0, '0);
      m_tag[5][2] = 12'h009;
      m_mesi[5][2] = 2'd1;
      m_tag[5][3] = 12'h00a;
      m_mesi[5][3] = 2'd2;
      issue(2'd1, 12'h009, 4'd5, 2'd0);
      wait_idle();
      issue(2'd1, 12'h00a, 4'd5, 2'd0);
      wait_idle();

      force_done = 15;
      issue(2'd0, 12'h007, 4'd6, 2'd0);
      to = 0;
      while (!(bus_busy && !bus_valid) && to < 100) begin
         @(negedge clk);
         to++;
      end
      if (to >= 100) bad("fill_wait_timeout");
      @(negedge clk);
      rst_n = 1'b0;
      exp_wr.delete();
      exp_lru.delete();
      exp_resp.delete();
      @(negedge clk);
      chk("midrst_bus_valid", bus_valid, 1'b0);
      chk("midrst_ready", req_ready, 1'b1);
      chk("midrst_no_wr", tag_wr_en, 1'b0);
      rst_n = 1'b1;
      force_done = -1;
      wait_idle();
      issue(2'd0, 12'h007, 4'd6, 2'd0);
      wait_idle();

      for (int i = 0; i < 250; i++) begin
         issue(2'($urandom_range(0, 3)), TAG_W'($urandom_range(0, 9)),
               4'($urandom_range(8, 11)), 2'($urandom_range(0, 2)));
      end
      wait_idle();
      chk("queues_drained", exp_bus.size() + exp_wr.size() + exp_lru.size() + exp_resp.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
